imm_ext_sched: RTL and testbench
================================

# imm_ext_sched

Scheduler that shares the single 16→32 immediate extender between two requesters in the dynamic pipeline: the decode stage (requester 0) and the address-generation unit (requester 1). Each cycle it arbitrates round-robin, runs the selected immediate through the extension mode the requester asks for, and holds the 32-bit result in a one-entry output register with a valid/ready handshake toward the consumer. A flush input discards the buffered result on pipeline redirect.

## Interface
- IMM_W, 16, immediate width in
- OUT_W, 32, extended width out
- TAG_W, 4, requester tag width carried with each result
- clk  in  1  clock, all flops on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an immediate to extend
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_imm / req1_imm  in  IMM_W  raw immediate
- req0_mode / req1_mode  in  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16), 11 sign-ext then <<2 (branch offset)
- req0_tag / req1_tag  in  TAG_W  opaque tag, returned unchanged
- flush  in  1  discard buffered result, block grants this cycle
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result
- out_data  out  OUT_W  extended value
- out_tag  out  TAG_W  tag of the granted request
- out_src  out  1  0 = requester 0, 1 = requester 1
- grant_cnt0 / grant_cnt1  out  16  accepted-request counters (see Configuration)

## Operation
- States: EMPTY (out_valid=0), FULL (out_valid=1).
- can_accept = !flush && (EMPTY || (FULL && out_ready)).
- Arbitration when can_accept: only one valid → grant it; both valid → grant requester != last_grant; none → no grant.
- last_grant flop updates only on a grant; reset value 1 (so requester 0 wins first tie).
- reqN_ready = can_accept && grant==N; at most one ready per cycle; ready never depends on reqN_valid of the other side beyond arbitration.
- Extension: mode 00 {16'h0, imm}; 01 {{16{imm[15]}}, imm}; 10 {imm, 16'h0}; 11 {{14{imm[15]}}, imm, 2'b00} (low 32 bits).
- Transitions: EMPTY+grant→FULL; FULL+out_ready+grant→FULL (new data); FULL+out_ready+no grant→EMPTY; FULL+!out_ready→FULL, outputs stable; any+flush→EMPTY, no grant.
- flush with out_ready in same cycle: flush wins, result dropped, consumer must ignore.
- Reset mid-operation: buffered result lost, state EMPTY immediately.

## Timing
- Latency: grant in cycle N → out_valid/out_data in cycle N+1.
- Throughput: one result per cycle when out_ready held high.
- Reset values: out_valid=0, out_data=0, out_tag=0, out_src=0, last_grant=1, grant_cnt0/1=0; req*_ready combinational, 0 while in reset.
- out_data/out_tag/out_src must not change while out_valid=1 and out_ready=0.
- reqN_ready is combinational from reqN_valid, out_ready, flush, state, last_grant; no combinational path from req*_imm to any output.

## Configuration
- IMM_EXT_SCHED_STATS_EN defined: grant_cnt0/grant_cnt1 increment on each accepted request of that requester, saturate at 16'hFFFF, clear on reset only (not on flush).
- Not defined: counter flops absent, grant_cnt0/grant_cnt1 tied to 0; all other behaviour identical.

## Test plan
- Reset: assert rst_n=0 mid-traffic with out_valid=1 → out_valid, out_data, counters read 0 asynchronously; first tie after release grants requester 0.
- Modes: req0 imm=16'h8001 modes 00/01/10/11 with out_ready=1 → 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004 one cycle after each grant.
- Round-robin: both valid 6 cycles, out_ready=1 → out_src 0,1,0,1,0,1; tags returned in matching order.
- Backpressure: out_ready=0 for 3 cycles with FULL → req*_ready=0, out_data stable; out_ready=1 → pending result consumed and next grant same cycle.
- Flush: FULL, flush=1 with req0_valid=1 and out_ready=1 → req0_ready=0, next cycle out_valid=0; following cycle req0 granted normally.
- Stats (macro defined): 70000 back-to-back req1 grants → grant_cnt1=16'hFFFF, grant_cnt0=0; without macro both read 0.

Source files
------------

// File: rtl/imm_ext_sched.sv
// ============================================================================
// imm_ext_sched: round-robin scheduler sharing one 16->32 immediate extender
// between decode (req 0) and AGU (req 1), with a one-entry result register.
// Optional: IMM_EXT_SCHED_STATS_EN enables saturating per-requester grant counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_ext_sched #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IMM_W-1:0] req0_imm,
  input  logic [1:0]       req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IMM_W-1:0] req1_imm,
  input  logic [1:0]       req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;

  logic             can_accept;
  logic             gnt_vld;
  logic             gnt_sel;
  logic [IMM_W-1:0] sel_imm;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] zext, sext, ext;

  // Arbitration: a tie goes to whichever requester did not win last.
  always_comb begin
    can_accept = !flush && ((state_q == ST_EMPTY) || out_ready);
    gnt_vld    = can_accept && (req0_valid || req1_valid);
    gnt_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (gnt_vld) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Output logic
  always_comb begin
    out_valid  = (state_q == ST_FULL);
    req0_ready = rst_n && gnt_vld && !gnt_sel;
    req1_ready = rst_n && gnt_vld && gnt_sel;
  end

  always_comb begin
    sel_imm  = gnt_sel ? req1_imm  : req0_imm;
    sel_mode = gnt_sel ? req1_mode : req0_mode;
    zext     = {{(OUT_W-IMM_W){1'b0}}, sel_imm};
    sext     = {{(OUT_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
    case (sel_mode)
      2'b00:   ext = zext;
      2'b01:   ext = sext;
      2'b10:   ext = zext << IMM_W;
      default: ext = sext << 2;
    endcase
  end

  // Result register only loads on a grant, so it stays stable under backpressure.
  always_comb begin
    data_d       = gnt_vld ? ext : data_q;
    tag_d        = gnt_vld ? (gnt_sel ? req1_tag : req0_tag) : tag_q;
    src_d        = gnt_vld ? gnt_sel : src_q;
    last_grant_d = gnt_vld ? gnt_sel : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      tag_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      data_q       <= data_d;
      tag_q        <= tag_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data = data_q;
  assign out_tag  = tag_q;
  assign out_src  = src_q;

`ifdef IMM_EXT_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + 16'((req0_ready && (cnt0_q != 16'hFFFF)) ? 1 : 0);
    cnt1_d = cnt1_q + 16'((req1_ready && (cnt1_q != 16'hFFFF)) ? 1 : 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 16'h0000;
  assign grant_cnt1 = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_sched.sv
// ============================================================================
// tb_imm_ext_sched: scoreboard bench for imm_ext_sched (directed vectors).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imm_ext_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_imm = '0, req1_imm = '0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_src;
  logic [15:0] grant_cnt0, grant_cnt1;

  imm_ext_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_imm(req0_imm),
    .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_imm(req1_imm),
    .req1_mode(req1_mode), .req1_tag(req1_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_src(out_src),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic        s;
  } exp_t;

  exp_t sb[$];
  exp_t dropped;
  int   checks = 0;
  int   failures = 0;

  logic        m_full = 1'b0;
  logic        m_last = 1'b1;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0;

  logic        hold_f = 1'b0;
  logic [36:0] hold_v = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: retires scoreboard entries when the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_f && out_valid)
        chk("stable_under_backpressure", {27'd0, out_data, out_tag, out_src}, {27'd0, hold_v});
      hold_f = 1'b0;
      if (out_valid && flush) begin
        if (sb.size() > 0) dropped = sb.pop_front();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", {32'd0, out_data}, {32'd0, e.d});
          chk("out_tag_src", {59'd0, out_tag, out_src}, {59'd0, e.t, e.s});
        end
      end else if (out_valid) begin
        hold_f = 1'b1;
        hold_v = {out_data, out_tag, out_src};
      end
    end
  end

  // One clock of stimulus plus the reference model of arbitration and state.
  task automatic cyc(input logic v0, input logic [15:0] i0, input logic [1:0] md0,
                     input logic [3:0] t0, input logic [31:0] x0,
                     input logic v1, input logic [15:0] i1, input logic [1:0] md1,
                     input logic [3:0] t1, input logic [31:0] x1,
                     input logic ordy, input logic fl);
    logic acc, g, sel;
    exp_t e;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_imm = i0; req0_mode = md0; req0_tag = t0;
    req1_valid = v1; req1_imm = i1; req1_mode = md1; req1_tag = t1;
    out_ready = ordy; flush = fl;
    #1;
    acc = !fl && (!m_full || ordy);
    g   = acc && (v0 || v1);
    sel = (v0 && v1) ? ~m_last : v1;
    chk("ready", {62'd0, req1_ready, req0_ready}, {62'd0, g && sel, g && !sel});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    chk("grant_cnt", {32'd0, grant_cnt1, grant_cnt0}, {32'd0, m_cnt1, m_cnt0});
    if (g) begin
      e.d = sel ? x1 : x0;
      e.t = sel ? t1 : t0;
      e.s = sel;
      sb.push_back(e);
      m_last = sel;
`ifdef IMM_EXT_SCHED_STATS_EN
      if (sel) begin if (m_cnt1 != 16'hFFFF) m_cnt1++; end
      else     begin if (m_cnt0 != 16'hFFFF) m_cnt0++; end
`endif
    end
    if (fl)                 m_full = 1'b0;
    else if (g)             m_full = 1'b1;
    else if (m_full && ordy) m_full = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_tag_src", {59'd0, out_tag, out_src}, 64'd0);
    chk("rst_cnt", {32'd0, grant_cnt1, grant_cnt0}, 64'd0);
    sb.delete();
    hold_f = 1'b0;
    m_full = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // First tie after reset goes to requester 0
    cyc(1, 16'h1234, 2'b00, 4'h1, 32'h00001234, 1, 16'h5678, 2'b00, 4'h2, 32'h00005678, 1, 0);

    // Extension modes on requester 0
    cyc(1, 16'h8001, 2'b00, 4'h3, 32'h00008001, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
    cyc(1, 16'h8001, 2'b01, 4'h4, 32'hFFFF8001, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
    cyc(1, 16'h8001, 2'b10, 4'h5, 32'h80010000, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
    cyc(1, 16'h8001, 2'b11, 4'h6, 32'hFFFE0004, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);

    // Round-robin with both requesters active
    for (int i = 0; i < 6; i++)
      cyc(1, 16'h00A0 + 16'(i), 2'b00, 4'(i), 32'h000000A0 + 32'(i),
          1, 16'hF000 + 16'(i), 2'b01, 4'(8 + i), 32'hFFFFF000 + 32'(i), 1, 0);

    // Backpressure: result held for 3 cycles, then consumed with a same-cycle grant
    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 16'h7FFF, 2'b11, 4'h7, 32'h0001FFFC, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 16'h0001, 2'b00, 4'h1, 32'h1, 1, 16'h0002, 2'b00, 4'h2, 32'h2, 0, 0);
    cyc(1, 16'h0040, 2'b10, 4'h9, 32'h00400000, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);

    // Flush while full and consumer ready: result dropped, no grant
    cyc(1, 16'h1111, 2'b00, 4'hA, 32'h00001111, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 1);
    cyc(1, 16'h2222, 2'b01, 4'hB, 32'h00002222, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);

    // Reset while a result is buffered
    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 16'hBEEF, 2'b01, 4'hC, 32'hFFFFBEEF, 0, 0);
    do_reset();
    cyc(1, 16'h0003, 2'b00, 4'hD, 32'h00000003, 1, 16'h0004, 2'b00, 4'hE, 32'h00000004, 1, 0);
    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);

    // Grant counters
    do_reset();
`ifdef IMM_EXT_SCHED_STATS_EN
    for (int i = 0; i < 70000; i++)
`else
    for (int i = 0; i < 20; i++)
`endif
      cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 16'(i), 2'b00, 4'(i), {16'h0, 16'(i)}, 1, 0);
    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
`ifdef IMM_EXT_SCHED_STATS_EN
    chk("cnt_saturated", {32'd0, grant_cnt1, grant_cnt0}, {32'd0, 16'hFFFF, 16'h0000});
`else
    chk("cnt_absent", {32'd0, grant_cnt1, grant_cnt0}, 64'd0);
`endif

    cyc(0, 16'h0, 2'b00, 4'h0, 32'h0, 0, 16'h0, 2'b00, 4'h0, 32'h0, 1, 0);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
